key_input_ctrl: RTL and testbench
=================================

Name: key_input_ctrl

Overview:
- User-input front end: the counterpart of the display controller. The display controller renders state, error_code and error_timer on the 7-seg and LEDs; this block produces the error fields and the accepted operand entries from the raw board buttons and DIP switches.
- It debounces the confirm and back buttons and range-checks the switch value on confirm.
- It emits one-cycle data_valid or back events to the main FSM.
- It owns the error_code/error_timer pair, including its countdown.

Parameters:
- DB_CYCLES, 2_000_000: consecutive stable cycles required to accept a button level change (20 ms at 100 MHz).
- TICK_CYCLES, 100_000_000: cycles per error-timer decrement (1 s at 100 MHz).
- MAX_VAL, 9: largest legal operand value.
- ERR_TIME, 10: initial error_timer value on a range error. Legal range 1..63.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_confirm_raw  in  1  raw confirm button, asynchronous, 1 = pressed.
- btn_back_raw  in  1  raw back button, asynchronous, 1 = pressed.
- sw_value  in  4  DIP-switch operand value. Quasi-static, sampled directly.
- accept_en  in  1  from main FSM; 1 = operand entry allowed.
- data_out  out  4  last accepted operand.
- data_valid  out  1  one-cycle pulse; data_out is updated on the same edge.
- back_pulse  out  1  one-cycle pulse per debounced back press.
- error_code  out  4  0 = none, 4'd1 = ERR_RANGE.
- error_timer  out  6  seconds remaining in the error display.

Behaviour:
- Reset (async, rst_n low): all outputs 0, synchronizers 0, debounce counters 0, stable levels 0, FSM = IDLE, tick counter 0. Reset mid-debounce or mid-error discards all state immediately.
- Synchronizer: each button passes through a 2-FF synchronizer (s1, s2).
- Debouncer (per button), on each edge:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Press event: registered pulse = stable & ~stable_prev, high for exactly one cycle. A raw level held from edge 1 produces the event at edge DB_CYCLES+3.
- Bounce handling: a glitch shorter than DB_CYCLES cycles produces no event. Release produces no event. A held button produces a single event.
- FSM state IDLE:
  - back event: back_pulse=1; the confirm event in the same cycle is dropped (back wins).
  - confirm event, accept_en=0: ignored, no outputs.
  - confirm event, accept_en=1, sw_value <= MAX_VAL: data_out <= sw_value, data_valid=1 on the next edge.
  - confirm event, accept_en=1, sw_value > MAX_VAL: go to ERROR. error_code <= 1, error_timer <= ERR_TIME, tick counter <= 0. data_out is unchanged.
- FSM state ERROR:
  - Tick counter increments each cycle.
  - At TICK_CYCLES-1: counter <= 0, error_timer <= error_timer-1.
  - If error_timer == 1 at that tick: error_timer <= 0, error_code <= 0, go to IDLE.
  - confirm events are ignored (no data_valid, timer not reloaded).
  - back event: back_pulse=1, error_code <= 0, error_timer <= 0, go to IDLE on the same edge. back takes priority over a coincident tick.
- Width rules: error_timer never underflows below 0. data_valid and back_pulse are never high in the same cycle.
- Latency: data_valid and error entry occur one edge after the confirm event pulse.

Test Plan (bench parameters DB_CYCLES=4, TICK_CYCLES=10, ERR_TIME=3, MAX_VAL=9):
1. Valid entry: sw_value=7, accept_en=1, confirm held for 20 cycles -> exactly one data_valid pulse with data_out=7, at edge DB_CYCLES+4 = 8 after raw rise. Release -> no further pulse.
2. Bounce: confirm toggled high 3 cycles, low 2, high 3, low -> no data_valid; data_out unchanged.
3. Range error: sw_value=12 + confirm -> error_code=1, error_timer=3. Timer reads 2, 1, 0 at 10-cycle intervals; error_code=0 together with timer 0. A confirm press during ERROR -> no data_valid.
4. Error cleared by back: in ERROR with error_timer=2, press back -> back_pulse once, error_code=0, error_timer=0 on the same edge. A following valid confirm (sw_value=3) -> data_out=3.
5. Gating and priority: accept_en=0 + confirm -> nothing. Confirm and back raw edges in the same cycle with accept_en=1 -> only back_pulse.
6. Async reset during ERROR and mid-debounce -> all outputs 0 immediately. A press starting after release of reset needs the full DB_CYCLES+3 to register.

Source files
------------

// File: rtl/key_input_ctrl.sv
// key_input_ctrl: user-input front end for the calculator board.
//   Debounces the confirm/back buttons, range-checks the DIP-switch operand
//   on confirm, emits one-cycle data_valid / back_pulse events and owns the
//   error_code / error_timer pair (including its 1 s countdown).
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   btn_confirm_raw   raw confirm button (async, 1 = pressed)
//   btn_back_raw      raw back button (async, 1 = pressed)
//   sw_value[3:0]     operand switches, sampled directly
//   accept_en         main FSM allows operand entry
//   data_out[3:0]     last accepted operand
//   data_valid        1-cycle pulse, data_out updated on the same edge
//   back_pulse        1-cycle pulse per debounced back press
//   error_code[3:0]   0 = none, 1 = ERR_RANGE
//   error_timer[5:0]  seconds left in the error display

// Per-button lane: 2-FF synchronizer, counter debouncer, rising-edge pulse.
module key_input_ctrl_db #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1_q, s1_d, s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d, prev_q, prev_d, press_q, press_d;

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // Any sample that agrees with the accepted level restarts the run.
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    prev_d  = stable_q;
    press_d = stable_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;
endmodule

module key_input_ctrl #(
  parameter int DB_CYCLES   = 2_000_000,
  parameter int TICK_CYCLES = 100_000_000,
  parameter int MAX_VAL     = 9,
  parameter int ERR_TIME    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_confirm_raw,
  input  logic       btn_back_raw,
  input  logic [3:0] sw_value,
  input  logic       accept_en,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       back_pulse,
  output logic [3:0] error_code,
  output logic [5:0] error_timer
);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_CYCLES - 1);
  localparam logic [3:0]    MAX_V     = 4'(MAX_VAL);
  localparam logic [5:0]    ERR_T     = 6'(ERR_TIME);
  localparam logic [3:0]    ERR_RANGE = 4'd1;

  typedef enum logic {ST_IDLE, ST_ERROR} state_t;

  // lane 0 = confirm, lane 1 = back
  logic [1:0] raw_vec, press_vec;
  assign raw_vec = {btn_back_raw, btn_confirm_raw};

  key_input_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw_vec),
    .press (press_vec)
  );

  logic confirm_ev, back_ev;
  assign confirm_ev = press_vec[0];
  assign back_ev    = press_vec[1];

  state_t        state_q, state_d;
  logic [3:0]    data_q, data_d, code_q, code_d;
  logic          valid_q, valid_d, back_q, back_d;
  logic [5:0]    timer_q, timer_d;
  logic [TW-1:0] tick_q, tick_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    code_d  = code_q;
    timer_d = timer_q;
    tick_d  = tick_q;
    valid_d = 1'b0;
    back_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // back wins over a coincident confirm
        if (back_ev) begin
          back_d = 1'b1;
        end else if (confirm_ev && accept_en) begin
          if (sw_value <= MAX_V) begin
            data_d  = sw_value;
            valid_d = 1'b1;
          end else begin
            state_d = ST_ERROR;
            code_d  = ERR_RANGE;
            timer_d = ERR_T;
            tick_d  = '0;
          end
        end
      end
      ST_ERROR: begin
        tick_d = tick_q + 1'b1;
        if (back_ev) begin
          back_d  = 1'b1;
          code_d  = '0;
          timer_d = '0;
          tick_d  = '0;
          state_d = ST_IDLE;
        end else if (tick_q == TICK_MAX) begin
          tick_d = '0;
          // <= 1 also keeps the timer from wrapping below zero
          if (timer_q <= 6'd1) begin
            timer_d = '0;
            code_d  = '0;
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q - 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      code_q  <= '0;
      timer_q <= '0;
      tick_q  <= '0;
      valid_q <= 1'b0;
      back_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      code_q  <= code_d;
      timer_q <= timer_d;
      tick_q  <= tick_d;
      valid_q <= valid_d;
      back_q  <= back_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign back_pulse  = back_q;
  assign error_code  = code_q;
  assign error_timer = timer_q;
endmodule

// File: tb/tb_key_input_ctrl.sv
module tb_key_input_ctrl;
  localparam int DB = 4, TK = 10, ET = 3, MV = 9;
  localparam int NR = 1500;

  logic       clk = 1'b0, rst_n = 1'b0, bc = 1'b0, bb = 1'b0, acc = 1'b0;
  logic [3:0] sw = '0;
  logic [3:0] dout, ec;
  logic       dv, bp;
  logic [5:0] et;

  key_input_ctrl #(.DB_CYCLES(DB), .TICK_CYCLES(TK), .MAX_VAL(MV), .ERR_TIME(ET)) dut (
    .clk(clk), .rst_n(rst_n), .btn_confirm_raw(bc), .btn_back_raw(bb),
    .sw_value(sw), .accept_en(acc), .data_out(dout), .data_valid(dv),
    .back_pulse(bp), .error_code(ec), .error_timer(et)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, n_dv = 0, n_bp = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // one clock edge, sample 1 time unit later
  task automatic cyc();
    @(posedge clk); #1;
    chk("excl_dv_bp", int'(dv & bp), 0);
    if (dv) n_dv++;
    if (bp) n_bp++;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_dout"}, dout, 0);
    chk({nm, "_dv"}, dv, 0);
    chk({nm, "_bp"}, bp, 0);
    chk({nm, "_ec"}, ec, 0);
    chk({nm, "_et"}, et, 0);
  endtask

  typedef struct {
    bit c; bit b; logic [3:0] sw; bit a; int hold;
    int edv; int ebp; int edata;
  } vec_t;
  vec_t tv[7];

  // reference model state (random phase)
  bit rh [2][NR+1];
  bit fu [2][NR+1];
  bit mst [2];
  int mflip [2];
  int err_start, m_dout;
  bit m_dv, m_bp;
  bit raw_r [2];
  int hold_r [2];

  function automatic bit rget(input int b, input int i);
    return (i < 1) ? 1'b0 : rh[b][i];
  endfunction

  // Debounced level flips once DB consecutive synchronized samples
  // (raw delayed 2 edges), all taken after the previous flip, disagree.
  task automatic model_step(input int n, input bit a, input int s);
    bit all, pc, pb;
    for (int b = 0; b < 2; b++) begin
      fu[b][n] = 1'b0;
      if (n - DB >= mflip[b]) begin
        all = 1'b1;
        for (int k = 0; k < DB; k++)
          if (rget(b, n - 2 - k) == mst[b]) all = 1'b0;
        if (all) begin
          mst[b] = ~mst[b];
          mflip[b] = n;
          fu[b][n] = mst[b];
        end
      end
    end
    // flip at edge f -> press pulse after f+1 -> acted on at f+2
    pc = (n >= 3) && fu[0][n-2];
    pb = (n >= 3) && fu[1][n-2];
    m_dv = 1'b0;
    m_bp = 1'b0;
    if (pb) begin
      m_bp = 1'b1;
      err_start = -1;
    end else if (err_start >= 0) begin
      if (n - err_start >= ET * TK) err_start = -1;
    end else if (pc && a) begin
      if (s <= MV) begin m_dout = s; m_dv = 1'b1; end
      else err_start = n;
    end
  endtask

  initial begin
    int first;
    tv[0] = '{1'b1, 1'b0, 4'd5,  1'b1, 10, 1, 0, 5};
    tv[1] = '{1'b1, 1'b0, 4'd3,  1'b0, 10, 0, 0, 5};
    tv[2] = '{1'b0, 1'b1, 4'd3,  1'b1, 10, 0, 1, 5};
    tv[3] = '{1'b1, 1'b1, 4'd2,  1'b1, 10, 0, 1, 5};
    tv[4] = '{1'b1, 1'b0, 4'd9,  1'b1, DB, 1, 0, 9};
    tv[5] = '{1'b1, 1'b0, 4'd6,  1'b1, DB - 1, 0, 0, 9};
    tv[6] = '{1'b1, 1'b0, 4'd8,  1'b1, 8, 1, 0, 8};

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("reset");

    // 1. valid entry, held 20 cycles
    sw = 4'd7; acc = 1'b1; bc = 1'b1; n_dv = 0; first = 0;
    for (int e = 1; e <= 20; e++) begin
      cyc();
      if (dv && first == 0) first = e;
    end
    chk("valid_edge", first, DB + 4);
    chk("valid_count", n_dv, 1);
    chk("valid_data", dout, 7);
    bc = 1'b0; n_dv = 0;
    repeat (15) cyc();
    chk("release_count", n_dv, 0);

    // 2. bounce: 3 high, 2 low, 3 high
    bc = 1'b1; repeat (3) cyc();
    bc = 1'b0; repeat (2) cyc();
    bc = 1'b1; repeat (3) cyc();
    bc = 1'b0; repeat (12) cyc();
    chk("bounce_count", n_dv, 0);
    chk("bounce_data", dout, 7);

    // table: gating, back, priority, hold boundary
    for (int i = 0; i < 7; i++) begin
      n_dv = 0; n_bp = 0;
      sw = tv[i].sw; acc = tv[i].a; bc = tv[i].c; bb = tv[i].b;
      repeat (tv[i].hold) cyc();
      bc = 1'b0; bb = 1'b0;
      repeat (12) cyc();
      chk($sformatf("tv%0d_dv", i), n_dv, tv[i].edv);
      chk($sformatf("tv%0d_bp", i), n_bp, tv[i].ebp);
      chk($sformatf("tv%0d_data", i), dout, tv[i].edata);
      chk($sformatf("tv%0d_ec", i), ec, 0);
    end

    // 3. range error and countdown; confirm during ERROR ignored
    sw = 4'd12; acc = 1'b1; bc = 1'b1;
    repeat (DB + 3) cyc();
    chk("err_pre_ec", ec, 0);
    cyc();
    chk("err_ec", ec, 1);
    chk("err_et", et, ET);
    sw = 4'd5; n_dv = 0;
    for (int j = 1; j <= 30; j++) begin
      bc = (j >= 12 && j < 20);
      cyc();
      if (j == 9)  chk("err_t9", et, 3);
      if (j == 10) chk("err_t10", et, 2);
      if (j == 19) chk("err_t19", et, 2);
      if (j == 20) chk("err_t20", et, 1);
      if (j == 29) begin chk("err_t29", et, 1); chk("err_ec29", ec, 1); end
      if (j == 30) begin chk("err_t30", et, 0); chk("err_ec30", ec, 0); end
    end
    chk("err_no_dv", n_dv, 0);
    chk("err_data", dout, 8);
    repeat (5) cyc();

    // 4. error cleared by back
    sw = 4'd12; bc = 1'b1;
    repeat (DB + 4) cyc();
    chk("err2_ec", ec, 1);
    bc = 1'b0;
    repeat (TK) cyc();
    chk("err2_et", et, 2);
    bb = 1'b1; n_bp = 0; first = 0;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      if (bp && first == 0) begin
        first = e;
        chk("back_ec", ec, 0);
        chk("back_et", et, 0);
      end
    end
    chk("back_edge", first, DB + 4);
    chk("back_count", n_bp, 1);
    bb = 1'b0;
    repeat (10) cyc();
    chk("back_et_hold", et, 0);
    sw = 4'd3; bc = 1'b1; n_dv = 0;
    repeat (10) cyc();
    bc = 1'b0;
    repeat (10) cyc();
    chk("after_back_data", dout, 3);
    chk("after_back_dv", n_dv, 1);

    // 6. async reset during ERROR with back mid-debounce
    sw = 4'd12; bc = 1'b1;
    repeat (DB + 4) cyc();
    chk("err3_ec", ec, 1);
    bc = 1'b0; bb = 1'b1;
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    bb = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    sw = 4'd4; acc = 1'b1; bc = 1'b1; first = 0;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      if (dv && first == 0) first = e;
    end
    chk("post_rst_edge", first, DB + 4);
    chk("post_rst_data", dout, 4);
    bc = 1'b0;
    repeat (10) cyc();

    // randomized run against the reference model
    rst_n = 1'b0; bc = 1'b0; bb = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    mst[0] = 1'b0; mst[1] = 1'b0; mflip[0] = 0; mflip[1] = 0;
    err_start = -1; m_dout = 0;
    raw_r[0] = 1'b0; raw_r[1] = 1'b0; hold_r[0] = 3; hold_r[1] = 20;
    for (int n = 1; n <= NR; n++) begin
      for (int b = 0; b < 2; b++) begin
        if (hold_r[b] == 0) begin
          raw_r[b] = ~raw_r[b];
          hold_r[b] = (b == 1 && !raw_r[b]) ? $urandom_range(5, 40) : $urandom_range(1, 9);
        end
        hold_r[b]--;
        rh[b][n] = raw_r[b];
      end
      if ($urandom_range(0, 7) == 0) sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) acc = ($urandom_range(0, 3) != 0);
      bc = raw_r[0]; bb = raw_r[1];
      cyc();
      model_step(n, acc, int'(sw));
      chk("r_dout", dout, m_dout);
      chk("r_dv", dv, m_dv);
      chk("r_bp", bp, m_bp);
      chk("r_ec", ec, (err_start >= 0) ? 1 : 0);
      chk("r_et", et, (err_start >= 0) ? ET - (n - err_start) / TK : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
